pwm_duty_ramp: RTL and testbench
================================

// Module: pwm_duty_ramp
// PURPOSE
//  Upstream duty-cycle sequencer for the basic R-bit PWM stage. Its duty output drives the PWM duty input.
//  Slews duty from its current value toward a loaded target by a programmable step. Updates only at PWM
//  period boundaries, so the PWM never sees a mid-period duty change. Provides soft-start and soft-stop.
// PARAMETERS
//  R       8  duty/period resolution in bits; must match the downstream PWM stage
//  RATE_W  4  width of rate divider; one step every (rate+1) PWM periods
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  load       in   1       1-cycle strobe: latch target, step, rate
//  target     in   R       requested final duty
//  step       in   R       duty increment/decrement per update; 0 is treated as 1
//  rate       in   RATE_W  periods per update minus 1
//  duty       out  R       duty value to the PWM stage
//  busy       out  1       1 while in RAMP_UP or RAMP_DOWN
//  at_target  out  1       1 when duty == latched target
//  period_end out  1       1-cycle pulse on the last clk of each PWM period (cnt == 2^R-1)
// BEHAVIOUR
//  Reset (async, immediate):
//   cnt=0, div=0, duty=0, tgt=0, stp=1, rt=0, state=IDLE, busy=0, at_target=1, period_end=0.
//  Period counter cnt: R-bit, free-running, wraps 2^R-1 -> 0. Mirrors the PWM stage's counter.
//  Rate divider div: counts period_end pulses. Update tick = period_end && div==rt; div clears on tick.
//  load: tgt/stp/rt register on that edge; div clears. On the next edge, state := UP if tgt>duty,
//   DOWN if tgt<duty, else IDLE. Loads in any state retarget; a reversal is allowed.
//  States:
//   IDLE: duty holds.
//   RAMP_UP: on tick, duty := (tgt-duty <= stp) ? tgt : duty+stp. Then IDLE when duty reaches tgt.
//   RAMP_DOWN: on tick, duty := (duty-tgt <= stp) ? tgt : duty-stp. Then IDLE when duty reaches tgt.
//  Arithmetic: differences computed unsigned in R bits (operand order by state). Never overshoots,
//   never wraps; duty stays in [0, 2^R-1].
//  Latency: duty changes only on the clk edge at the end of a cnt==2^R-1 cycle. The new duty
//   applies from cnt==0 of the next period.
//  Simultaneous load and tick: the tick uses the old tgt/stp; the new values apply from the next tick.
//  load with target==duty: state -> IDLE, at_target=1, duty unchanged.
//  at_target and busy are registered and consistent with duty in the same cycle.
//  reset asserted mid-ramp: duty drops to 0 immediately (asynchronous); the ramp is abandoned.
// CONFIGURATION
//  PWM_RAMP_DONE_PULSE_EN defined:
//   adds output done (1 bit, reset 0).
//   done = 1-cycle pulse on the edge where a ramp state returns to IDLE with duty==tgt.
//   No pulse for a load with target==duty.
//  Not defined: no done port; all other behaviour identical.
// STRUCTURE
//  Package pwm_pkg: state encoding localparams ST_IDLE=2'd0, ST_UP=2'd1, ST_DOWN=2'd2; default R.
//  Sub-module pwm_period_tick (R, RATE_W): holds cnt and div, emits period_end and tick.
//  Top level holds the FSM, target/step registers and the saturating step arithmetic.
// TESTING (R=8, RATE_W=4, clk period 10 ns)
//  1. Hold reset high, then release -> duty=0, at_target=1, busy=0; period_end every 256 clk.
//  2. Load target=64, step=16, rate=0 -> duty 16,32,48,64 at the next 4 period ends; then busy=0,
//     at_target=1; done pulses once when the macro is set.
//  3. From duty=64, load target=0, step=40, rate=1 -> duty 24, then 0, every 2 periods;
//     no wrap below 0.
//  4. Load target=255, step=100, rate=0 -> duty 100,200,255; saturates with no overshoot.
//  5. Assert load in the same cycle as period_end -> that update uses the old target; the new
//     target applies from the next period; a reversal mid-ramp switches to RAMP_DOWN.
//  6. Assert reset mid-ramp (duty=48) for 2 ns -> duty=0 and state IDLE without waiting for a
//     clk edge; the next load ramps up from 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty ramp: state encoding and default resolution.
`default_nettype none

package pwm_pkg;

    localparam int PWM_R_DEFAULT = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_UP   = ST_UP,
        S_DOWN = ST_DOWN
    } state_e;

endpackage

`default_nettype wire

// File: rtl/pwm_period_tick.sv
// Free-running PWM period counter plus rate divider; emits period_end and the update tick.
`default_nettype none

module pwm_period_tick #(
    parameter int R      = 8,
    parameter int RATE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic [RATE_W-1:0] rt_i,
    output logic              period_end_o,
    output logic              tick_o
);

    logic [R-1:0]      cnt_q;
    logic [RATE_W-1:0] div_q;
    logic [RATE_W-1:0] div_d;

    assign period_end_o = (cnt_q == {R{1'b1}});
    assign tick_o       = period_end_o && (div_q == rt_i);

    always_comb begin
        div_d = div_q;
        if (clr_i || tick_o) begin
            div_d = '0;
        end else if (period_end_o) begin
            div_d = div_q + RATE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            div_q <= '0;
        end else begin
            cnt_q <= cnt_q + R'(1);
            div_q <= div_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle slew sequencer for the R-bit PWM stage; updates only on period boundaries.
// Optional macro PWM_RAMP_DONE_PULSE_EN adds a one-cycle done pulse at ramp completion.
`default_nettype none

module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int R      = PWM_R_DEFAULT,
    parameter int RATE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [R-1:0]      target,
    input  logic [R-1:0]      step,
    input  logic [RATE_W-1:0] rate,
    output logic [R-1:0]      duty,
    output logic              busy,
    output logic              at_target,
    output logic              period_end
`ifdef PWM_RAMP_DONE_PULSE_EN
    ,
    output logic              done
`endif
);

    state_e            state_q, state_d, w_dir;
    logic [R-1:0]      duty_q, duty_d;
    logic [R-1:0]      tgt_q, tgt_d;
    logic [R-1:0]      stp_q, stp_d;
    logic [R-1:0]      w_diff;
    logic [RATE_W-1:0] rt_q, rt_d;
    logic              eval_q;
    logic              busy_q;
    logic              at_target_q;
    logic              done_q, done_d;
    logic              w_tick;

    pwm_period_tick #(
        .R      (R),
        .RATE_W (RATE_W)
    ) u_tick (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (load),
        .rt_i         (rt_q),
        .period_end_o (period_end),
        .tick_o       (w_tick)
    );

    always_comb begin
        tgt_d = tgt_q;
        stp_d = stp_q;
        rt_d  = rt_q;
        if (load) begin
            tgt_d = target;
            stp_d = (step == '0) ? R'(1) : step;
            rt_d  = rate;
        end

        // Direction is re-derived the edge after a load; otherwise it is the current state.
        w_dir = state_q;
        if (eval_q) begin
            if (tgt_q > duty_q) begin
                w_dir = S_UP;
            end else if (tgt_q < duty_q) begin
                w_dir = S_DOWN;
            end else begin
                w_dir = S_IDLE;
            end
        end

        duty_d = duty_q;
        w_diff = '0;
        if (w_tick) begin
            case (w_dir)
                S_UP: begin
                    w_diff = tgt_q - duty_q;
                    duty_d = (w_diff <= stp_q) ? tgt_q : duty_q + stp_q;
                end
                S_DOWN: begin
                    w_diff = duty_q - tgt_q;
                    duty_d = (w_diff <= stp_q) ? tgt_q : duty_q - stp_q;
                end
                default: ;
            endcase
        end

        state_d = (duty_d == tgt_q) ? S_IDLE : w_dir;
        done_d  = w_tick && (w_dir != S_IDLE) && (duty_d == tgt_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            duty_q      <= '0;
            tgt_q       <= '0;
            stp_q       <= R'(1);
            rt_q        <= '0;
            eval_q      <= 1'b0;
            busy_q      <= 1'b0;
            at_target_q <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            tgt_q       <= tgt_d;
            stp_q       <= stp_d;
            rt_q        <= rt_d;
            eval_q      <= load;
            busy_q      <= (state_d != S_IDLE);
            at_target_q <= (duty_d == tgt_d);
            done_q      <= done_d;
        end
    end

    assign duty      = duty_q;
    assign busy      = busy_q;
    assign at_target = at_target_q;

`ifdef PWM_RAMP_DONE_PULSE_EN
    assign done = done_q;
`else
    logic w_done_unused;
    assign w_done_unused = done_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp (R=8, RATE_W=4, 10 ns clock).
`default_nettype none

module tb_pwm_duty_ramp;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] target = '0;
    logic [7:0] step = '0;
    logic [3:0] rate = '0;
    logic [7:0] duty;
    logic       busy;
    logic       at_target;
    logic       period_end;
`ifdef PWM_RAMP_DONE_PULSE_EN
    logic       done;
`endif

    int checks = 0;
    int failures = 0;

    pwm_duty_ramp #(.R(8), .RATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .target     (target),
        .step       (step),
        .rate       (rate),
        .duty       (duty),
        .busy       (busy),
        .at_target  (at_target),
        .period_end (period_end)
`ifdef PWM_RAMP_DONE_PULSE_EN
        ,
        .done       (done)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_pe();
        int n;
        n = 0;
        @(negedge clk);
        while (period_end !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) begin
            checks++;
            failures++;
            $error("FAIL pe_timeout: observed=no period_end expected=period_end within 600 clk");
        end
    endtask

    task automatic do_load(input logic [7:0] t, input logic [7:0] s, input logic [3:0] r);
        target = t;
        step   = s;
        rate   = r;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic next_update();
        wait_pe();
        @(negedge clk);
    endtask

    initial begin
        int n;

        // 1: reset state and period length
        repeat (3) @(negedge clk);
        chk("rst_duty", duty, 0);
        chk("rst_pe", period_end, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_duty", duty, 0);
        chk("rel_at_target", at_target, 1);
        chk("rel_busy", busy, 0);
        wait_pe();
        n = 1;
        @(negedge clk);
        while (period_end !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("period_len", n, 256);
        @(negedge clk);

        // 2: ramp up 0 -> 64 by 16, rate 0
        do_load(8'd64, 8'd16, 4'd0);
        next_update();
        chk("up_16", duty, 16);
        chk("up_busy", busy, 1);
        chk("up_at_target", at_target, 0);
`ifdef PWM_RAMP_DONE_PULSE_EN
        chk("up_done_early", done, 0);
`endif
        next_update();
        chk("up_32", duty, 32);
        next_update();
        chk("up_48", duty, 48);
        next_update();
        chk("up_64", duty, 64);
        chk("up_end_busy", busy, 0);
        chk("up_end_at_target", at_target, 1);
`ifdef PWM_RAMP_DONE_PULSE_EN
        chk("up_done_pulse", done, 1);
`endif
        @(negedge clk);
`ifdef PWM_RAMP_DONE_PULSE_EN
        chk("up_done_clear", done, 0);
`endif

        // 3: ramp down 64 -> 0 by 40, every 2 periods
        do_load(8'd0, 8'd40, 4'd1);
        next_update();
        chk("dn_hold1", duty, 64);
        next_update();
        chk("dn_24", duty, 24);
        next_update();
        chk("dn_hold2", duty, 24);
        next_update();
        chk("dn_0", duty, 0);
        chk("dn_busy", busy, 0);
        chk("dn_at_target", at_target, 1);
        next_update();
        next_update();
        chk("dn_no_wrap", duty, 0);

        // 4: saturate at 255
        do_load(8'd255, 8'd100, 4'd0);
        next_update();
        chk("sat_100", duty, 100);
        next_update();
        chk("sat_200", duty, 200);
        next_update();
        chk("sat_255", duty, 255);
        chk("sat_at_target", at_target, 1);

        // load with target equal to duty
        do_load(8'd255, 8'd1, 4'd0);
        @(negedge clk);
        chk("eq_busy", busy, 0);
        chk("eq_at_target", at_target, 1);
`ifdef PWM_RAMP_DONE_PULSE_EN
        chk("eq_no_done", done, 0);
`endif
        next_update();
        chk("eq_duty", duty, 255);

        // 5: load coincident with period_end, then reversal
        do_load(8'd0, 8'd50, 4'd0);
        next_update();
        chk("co_205", duty, 205);
        wait_pe();
        do_load(8'd255, 8'd10, 4'd0);
        chk("co_old_tgt", duty, 155);
        chk("co_busy", busy, 1);
        next_update();
        chk("co_new_tgt", duty, 165);
        do_load(8'd100, 8'd5, 4'd0);
        next_update();
        chk("rev_160", duty, 160);
        chk("rev_busy", busy, 1);
        do_load(8'd48, 8'd112, 4'd0);
        next_update();
        chk("rev_48", duty, 48);
        chk("rev_idle", busy, 0);

        // 6: asynchronous reset mid-ramp
        do_load(8'd200, 8'd1, 4'd15);
        repeat (2) @(negedge clk);
        chk("mid_busy", busy, 1);
        chk("mid_duty", duty, 48);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("arst_duty", duty, 0);
        chk("arst_busy", busy, 0);
        chk("arst_at_target", at_target, 1);
        @(negedge clk);
        do_load(8'd32, 8'd16, 4'd0);
        next_update();
        chk("post_16", duty, 16);
        next_update();
        chk("post_32", duty, 32);

        // step of zero behaves as one
        do_load(8'd34, 8'd0, 4'd0);
        next_update();
        chk("stp0_33", duty, 33);
        next_update();
        chk("stp0_34", duty, 34);
        chk("stp0_at_target", at_target, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
